// File: rtl/id_issue_scoreboard_if.sv
// Decode-to-EX handshake bundle for id_issue_scoreboard: decode slot in, registered controls out.
// slave = scoreboard side, master = surrounding pipeline / testbench side.
interface id_issue_scoreboard_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic                  rs1_re;
    logic                  rs2_re;
    logic                  rd_we;
    logic                  mem_re;
    logic                  mem_we;
    logic                  illegal;
    logic [REG_ADDR_W-1:0] out_rd_addr;

    modport slave (
        input  in_valid, opcode, funct3, funct7, rs1_addr, rs2_addr, rd_addr, out_ready,
        output in_ready, out_valid, rs1_re, rs2_re, rd_we, mem_re, mem_we, illegal, out_rd_addr
    );

    modport master (
        output in_valid, opcode, funct3, funct7, rs1_addr, rs2_addr, rd_addr, out_ready,
        input  in_ready, out_valid, rs1_re, rs2_re, rd_we, mem_re, mem_we, illegal, out_rd_addr
    );
endinterface

// File: rtl/id_issue_scoreboard.sv
// RV32I decode-stage issue controller with per-register RAW scoreboard and 1-entry output stage.
// Define SCB_FORWARD_EN when an EX/MEM bypass exists: only load-use then stalls (one bubble).
module id_issue_scoreboard #(
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_LAT    = 2,
    parameter int unsigned LOAD_LAT   = 3,
    parameter int unsigned CNT_W      = 3
) (
    input logic                          clk,
    input logic                          rst,
    input logic                          flush,
    id_issue_scoreboard_if.slave         dec_io
);
    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] OpReg  = 7'b0110011;
    localparam logic [6:0] OpLoad = 7'b0000011;
    localparam logic [6:0] OpStor = 7'b0100011;
    localparam logic [6:0] OpBrch = 7'b1100011;
    localparam logic [6:0] OpLui  = 7'b0110111;
    localparam logic [6:0] OpAuip = 7'b0010111;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpJalr = 7'b1100111;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    localparam logic [CNT_W-1:0] AluCnt = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LdCnt  = CNT_W'(LOAD_LAT);

    logic       legal;
    logic       rs1_dec, rs2_dec, rd_dec, mrd_dec, mwr_dec;
    logic       rs1_re_dec, rs2_re_dec, rd_we_dec, mem_re_dec, mem_we_dec, illegal_dec;
    logic       pend_rs1, pend_rs2, hazard, issue;

    logic [CNT_W-1:0] cnt_q [REG_NUM];
    logic [CNT_W-1:0] cnt_d [REG_NUM];

    logic                  out_valid_q, out_valid_d;
    logic                  rs1_re_q, rs1_re_d;
    logic                  rs2_re_q, rs2_re_d;
    logic                  rd_we_q, rd_we_d;
    logic                  mem_re_q, mem_re_d;
    logic                  mem_we_q, mem_we_d;
    logic                  illegal_q, illegal_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;

    always_comb begin
        legal   = 1'b1;
        rs1_dec = 1'b0;
        rs2_dec = 1'b0;
        rd_dec  = 1'b0;
        mrd_dec = 1'b0;
        mwr_dec = 1'b0;
        case (dec_io.opcode)
            OpImm: begin
                rs1_dec = 1'b1;
                rd_dec  = 1'b1;
                if (dec_io.funct3 == 3'b001) begin
                    legal = (dec_io.funct7 == 7'd0);
                end else if (dec_io.funct3 == 3'b101) begin
                    legal = (dec_io.funct7 == 7'd0) || (dec_io.funct7 == F7Alt);
                end
            end
            OpReg: begin
                rs1_dec = 1'b1;
                rs2_dec = 1'b1;
                rd_dec  = 1'b1;
                legal   = (dec_io.funct7 == 7'd0) ||
                          ((dec_io.funct7 == F7Alt) &&
                           ((dec_io.funct3 == 3'b000) || (dec_io.funct3 == 3'b101)));
            end
            OpLoad: begin
                rs1_dec = 1'b1;
                rd_dec  = 1'b1;
                mrd_dec = 1'b1;
                legal   = (dec_io.funct3 != 3'b011) && (dec_io.funct3 != 3'b110) &&
                          (dec_io.funct3 != 3'b111);
            end
            OpStor: begin
                rs1_dec = 1'b1;
                rs2_dec = 1'b1;
                mwr_dec = 1'b1;
                legal   = (dec_io.funct3 <= 3'b010);
            end
            OpBrch: begin
                rs1_dec = 1'b1;
                rs2_dec = 1'b1;
                legal   = (dec_io.funct3 != 3'b010) && (dec_io.funct3 != 3'b011);
            end
            OpLui, OpAuip, OpJal: rd_dec = 1'b1;
            OpJalr: begin
                rs1_dec = 1'b1;
                rd_dec  = 1'b1;
                legal   = (dec_io.funct3 == 3'b000);
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal encodings carry no enables so they can never touch the scoreboard.
    assign rs1_re_dec  = legal & rs1_dec;
    assign rs2_re_dec  = legal & rs2_dec;
    assign rd_we_dec   = legal & rd_dec & (dec_io.rd_addr != '0);
    assign mem_re_dec  = legal & mrd_dec;
    assign mem_we_dec  = legal & mwr_dec;
    assign illegal_dec = ~legal;

`ifdef SCB_FORWARD_EN
    logic is_ld_q [REG_NUM];
    logic is_ld_d [REG_NUM];

    // With bypass, only a load still in its first cycle after issue is unreachable.
    assign pend_rs1 = is_ld_q[dec_io.rs1_addr] && (cnt_q[dec_io.rs1_addr] == LdCnt);
    assign pend_rs2 = is_ld_q[dec_io.rs2_addr] && (cnt_q[dec_io.rs2_addr] == LdCnt);
`else
    assign pend_rs1 = (cnt_q[dec_io.rs1_addr] != '0);
    assign pend_rs2 = (cnt_q[dec_io.rs2_addr] != '0);
`endif

    assign hazard          = (rs1_re_dec & pend_rs1) | (rs2_re_dec & pend_rs2);
    assign dec_io.in_ready = (~out_valid_q | dec_io.out_ready) & ~hazard & ~flush;
    assign issue           = dec_io.in_valid & dec_io.in_ready;

    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            cnt_d[r] = cnt_q[r];
            if (dec_io.out_ready && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
            if (issue && rd_we_dec && (dec_io.rd_addr == REG_ADDR_W'(r))) begin
                cnt_d[r] = mem_re_dec ? LdCnt : AluCnt;
            end
        end
    end

`ifdef SCB_FORWARD_EN
    always_comb begin
        is_ld_d[0] = 1'b0;
        for (int r = 1; r < REG_NUM; r++) begin
            is_ld_d[r] = is_ld_q[r];
            if (issue && rd_we_dec && (dec_io.rd_addr == REG_ADDR_W'(r))) begin
                is_ld_d[r] = mem_re_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_ld_q <= '{default: 1'b0};
        end else begin
            is_ld_q <= is_ld_d;
        end
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        rs1_re_d    = rs1_re_q;
        rs2_re_d    = rs2_re_q;
        rd_we_d     = rd_we_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        illegal_d   = illegal_q;
        rd_addr_d   = rd_addr_q;
        if (issue) begin
            out_valid_d = 1'b1;
            rs1_re_d    = rs1_re_dec;
            rs2_re_d    = rs2_re_dec;
            rd_we_d     = rd_we_dec;
            mem_re_d    = mem_re_dec;
            mem_we_d    = mem_we_dec;
            illegal_d   = illegal_dec;
            rd_addr_d   = dec_io.rd_addr;
        end else if (flush || dec_io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            rs1_re_q    <= 1'b0;
            rs2_re_q    <= 1'b0;
            rd_we_q     <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            illegal_q   <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            rs1_re_q    <= rs1_re_d;
            rs2_re_q    <= rs2_re_d;
            rd_we_q     <= rd_we_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            illegal_q   <= illegal_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign dec_io.out_valid   = out_valid_q;
    assign dec_io.rs1_re      = rs1_re_q;
    assign dec_io.rs2_re      = rs2_re_q;
    assign dec_io.rd_we       = rd_we_q;
    assign dec_io.mem_re      = mem_re_q;
    assign dec_io.mem_we      = mem_we_q;
    assign dec_io.illegal     = illegal_q;
    assign dec_io.out_rd_addr = rd_addr_q;
endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Directed bench for id_issue_scoreboard; stall expectations follow SCB_FORWARD_EN.
module tb_id_issue_scoreboard;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   stalls;

`ifdef SCB_FORWARD_EN
    localparam int ExpAluStall = 0;
    localparam int ExpLdStall  = 1;
`else
    localparam int ExpAluStall = 2;
    localparam int ExpLdStall  = 3;
`endif

    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] OpReg  = 7'b0110011;
    localparam logic [6:0] OpLoad = 7'b0000011;
    localparam logic [6:0] OpStor = 7'b0100011;

    id_issue_scoreboard_if #(.REG_ADDR_W(5)) bus ();

    id_issue_scoreboard dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .dec_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.rs1_addr = a1;
        bus.rs2_addr = a2;
        bus.rd_addr  = ad;
    endtask

    // Holds the instruction until it issues; returns cycles spent stalled (99 on timeout).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                             output int n);
        set_instr(op, f3, f7, a1, a2, ad);
        bus.in_valid = 1'b1;
        n = 0;
        #1;
        while (!bus.in_ready && n < 20) begin
            cyc();
            n++;
            #1;
        end
        if (!bus.in_ready) n = 99;
        else cyc();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_instr(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_rd_we", bus.rd_we, 0);
        check_eq("rst_illegal", bus.illegal, 0);
        check_eq("rst_rd_addr", bus.out_rd_addr, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);

        // ADDI x1, x0 then dependent ADD x2, x1, x1
        run_instr(OpImm, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, stalls);
        check_eq("addi_stall", stalls, 0);
        check_eq("addi_valid", bus.out_valid, 1);
        check_eq("addi_rs1_re", bus.rs1_re, 1);
        check_eq("addi_rs2_re", bus.rs2_re, 0);
        check_eq("addi_rd_we", bus.rd_we, 1);
        check_eq("addi_rd", bus.out_rd_addr, 1);
        check_eq("addi_illegal", bus.illegal, 0);
        run_instr(OpReg, 3'd0, 7'd0, 5'd1, 5'd1, 5'd2, stalls);
        check_eq("add_raw_stall", stalls, ExpAluStall);
        check_eq("add_rs2_re", bus.rs2_re, 1);
        check_eq("add_rd", bus.out_rd_addr, 2);
        cyc();
        check_eq("drain_valid", bus.out_valid, 0);
        repeat (4) cyc();

        // Load-use
        run_instr(OpLoad, 3'd2, 7'd0, 5'd0, 5'd0, 5'd5, stalls);
        check_eq("lw_stall", stalls, 0);
        check_eq("lw_mem_re", bus.mem_re, 1);
        check_eq("lw_rd_we", bus.rd_we, 1);
        check_eq("lw_mem_we", bus.mem_we, 0);
        run_instr(OpReg, 3'd0, 7'd0, 5'd5, 5'd0, 5'd6, stalls);
        check_eq("ld_use_stall", stalls, ExpLdStall);
        repeat (5) cyc();

        // Back-pressure freezes the load's counter and the output entry
        run_instr(OpLoad, 3'd2, 7'd0, 5'd0, 5'd0, 5'd5, stalls);
        bus.out_ready = 1'b0;
        set_instr(OpReg, 3'd0, 7'd0, 5'd5, 5'd0, 5'd6);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("bp_in_ready", bus.in_ready, 0);
            check_eq("bp_valid", bus.out_valid, 1);
            check_eq("bp_rd", bus.out_rd_addr, 5);
            check_eq("bp_mem_re", bus.mem_re, 1);
            cyc();
        end
        bus.out_ready = 1'b1;
        run_instr(OpReg, 3'd0, 7'd0, 5'd5, 5'd0, 5'd6, stalls);
        check_eq("bp_resume_stall", stalls, ExpLdStall);
        repeat (5) cyc();

        // Illegal encodings issue with no enables and never mark rd
        run_instr(7'b1111111, 3'd0, 7'd0, 5'd4, 5'd0, 5'd3, stalls);
        check_eq("ill_stall", stalls, 0);
        check_eq("ill_flag", bus.illegal, 1);
        check_eq("ill_rd_we", bus.rd_we, 0);
        check_eq("ill_rs1_re", bus.rs1_re, 0);
        check_eq("ill_mem", {bus.mem_re, bus.mem_we}, 0);
        run_instr(OpReg, 3'd0, 7'd0, 5'd3, 5'd3, 5'd7, stalls);
        check_eq("after_ill_stall", stalls, 0);
        run_instr(OpReg, 3'd1, 7'b0100000, 5'd0, 5'd0, 5'd8, stalls);
        check_eq("op_bad_f7_ill", bus.illegal, 1);
        run_instr(OpStor, 3'd2, 7'd0, 5'd0, 5'd0, 5'd9, stalls);
        check_eq("sw_mem_we", bus.mem_we, 1);
        check_eq("sw_rs2_re", bus.rs2_re, 1);
        check_eq("sw_rd_we", bus.rd_we, 0);
        check_eq("sw_illegal", bus.illegal, 0);
        repeat (4) cyc();

        // x0 destination is untracked
        run_instr(OpImm, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, stalls);
        check_eq("x0_rd_we", bus.rd_we, 0);
        run_instr(OpReg, 3'd0, 7'd0, 5'd0, 5'd0, 5'd8, stalls);
        check_eq("x0_read_stall", stalls, 0);
        repeat (4) cyc();

        // Flush kills same-cycle issue
        set_instr(OpImm, 3'd0, 7'd0, 5'd0, 5'd0, 5'd9);
        bus.in_valid = 1'b1;
        flush        = 1'b1;
        #1;
        check_eq("flush_in_ready", bus.in_ready, 0);
        cyc();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("flush_valid", bus.out_valid, 0);
        run_instr(OpReg, 3'd0, 7'd0, 5'd9, 5'd9, 5'd10, stalls);
        check_eq("flush_no_mark", stalls, 0);
        repeat (4) cyc();

        // Reset while a dependent is stalled
        run_instr(OpImm, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, stalls);
        set_instr(OpReg, 3'd0, 7'd0, 5'd1, 5'd1, 5'd2);
        bus.in_valid = 1'b1;
        #1;
`ifndef SCB_FORWARD_EN
        check_eq("pre_rst_stall", bus.in_ready, 0);
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", bus.in_ready, 1);
        check_eq("post_rst_valid", bus.out_valid, 0);
        bus.in_valid = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
